// File: rtl/serial_add_ctrl.sv
// Multi-cycle wide adder controller: drives one external WORD_BITS adder slice per cycle and
// ripples the carry through a register. Optional subtract mode under SERIAL_ADD_SUB_EN.
module serial_add_ctrl #(
   parameter int unsigned WORD_BITS = 4,
   parameter int unsigned NUM_WORDS = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
`ifdef SERIAL_ADD_SUB_EN
   input  logic                           sub,
`endif
   input  logic [WORD_BITS*NUM_WORDS-1:0] op_a,
   input  logic [WORD_BITS*NUM_WORDS-1:0] op_b,
   input  logic                           carry_in,
   output logic                           busy,
   output logic                           done,
   output logic [WORD_BITS*NUM_WORDS-1:0] result,
   output logic                           overflow,
   output logic [WORD_BITS-1:0]           add_a,
   output logic [WORD_BITS-1:0]           add_b,
   output logic                           add_cin,
   input  logic [WORD_BITS-1:0]           add_sum,
   input  logic                           add_ovf
);

   localparam int unsigned W     = WORD_BITS * NUM_WORDS;
   localparam int unsigned IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [W-1:0]     a_q, a_d;
   logic [W-1:0]     b_q, b_d;
   logic             carry_q, carry_d;
   logic [W-1:0]     partial_q, partial_d;
   logic [W-1:0]     result_q, result_d;
   logic             overflow_q, overflow_d;

   logic             accept;
   logic             last_slice;
   logic [W-1:0]     b_load;
   logic             cin_load;
   logic [W-1:0]     merged;

   assign accept     = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
   assign last_slice = (idx_q == LAST_IDX);

`ifdef SERIAL_ADD_SUB_EN
   // Subtraction as A + ~B + 1; the final carry-out then means "no borrow".
   assign b_load   = sub ? ~op_b : op_b;
   assign cin_load = sub ? 1'b1 : carry_in;
`else
   assign b_load   = op_b;
   assign cin_load = carry_in;
`endif

   // Partial sum with the slice currently on the adder already folded in.
   always_comb begin
      merged = partial_q;
      merged[idx_q*WORD_BITS +: WORD_BITS] = add_sum;
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      a_d        = a_q;
      b_d        = b_q;
      carry_d    = carry_q;
      partial_d  = partial_q;
      result_d   = result_q;
      overflow_d = overflow_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (accept) begin
               a_d       = op_a;
               b_d       = b_load;
               carry_d   = cin_load;
               idx_d     = '0;
               partial_d = '0;
               state_d   = ST_CALC;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CALC: begin
            partial_d = merged;
            carry_d   = add_ovf;
            idx_d     = idx_q + 1'b1;
            if (last_slice) begin
               result_d   = merged;
               overflow_d = add_ovf;
               idx_d      = '0;
               state_d    = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         a_q        <= '0;
         b_q        <= '0;
         carry_q    <= 1'b0;
         partial_q  <= '0;
         result_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         a_q        <= a_d;
         b_q        <= b_d;
         carry_q    <= carry_d;
         partial_q  <= partial_d;
         result_q   <= result_d;
         overflow_q <= overflow_d;
      end
   end

   assign busy     = (state_q == ST_CALC);
   assign done     = (state_q == ST_DONE);
   assign result   = result_q;
   assign overflow = overflow_q;

   // Adder is only driven while calculating; quiet otherwise.
   always_comb begin
      add_a   = '0;
      add_b   = '0;
      add_cin = 1'b0;
      if (state_q == ST_CALC) begin
         add_a   = a_q[idx_q*WORD_BITS +: WORD_BITS];
         add_b   = b_q[idx_q*WORD_BITS +: WORD_BITS];
         add_cin = carry_q;
      end
   end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Multi-cycle controller that sequences one external `adder_nbit` instance to perform a wide addition, one WORD_BITS-wide slice per clock cycle. It rippls the carry between slices through an internal register. It sits between a requester (start/done handshake) and the shared n-bit adder datapath, driving the adder's operands and carry-in and capturing its sum and overflow. Wide adds are built from the small adder without widening the datapath.

## Interface
- WORD_BITS, 4, width of the external adder slice (matches `adder_nbit` a/b/sum width)
- NUM_WORDS, 4, number of slices; operand width W = WORD_BITS*NUM_WORDS (16 by default)

- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE or DONE
- op_a  in  W  operand A, latched on accepted start
- op_b  in  W  operand B, latched on accepted start
- carry_in  in  1  initial carry, latched on accepted start
- busy  out  1  high while in CALC
- done  out  1  one-cycle pulse in DONE
- result  out  W  final sum, held until the next completion
- overflow  out  1  carry-out of the most significant slice, held with result
- add_a  out  WORD_BITS  to adder a
- add_b  out  WORD_BITS  to adder b
- add_cin  out  1  to adder carry_in
- add_sum  in  WORD_BITS  from adder sum
- add_ovf  in  1  from adder overflow (slice carry-out)

## Operation
- Reset values: the FSM is in IDLE. busy=0, done=0, result=0, overflow=0. add_a, add_b and add_cin are 0. The internal slice index, carry register and operand registers are 0.
- States:
  - IDLE: if start=1, latch op_a, op_b and carry_in into the carry register, set idx=0, and go to CALC. Otherwise stay in IDLE.
  - CALC: present slice idx to the adder. At each edge:
    - write add_sum into partial[idx*WORD_BITS +: WORD_BITS]
    - set carry register = add_ovf
    - set idx = idx+1
    - when idx==NUM_WORDS-1, copy the full partial, including the current slice, into result, set overflow=add_ovf, and go to DONE.
  - DONE: done=1 for one cycle. If start=1, accept the new request exactly as in IDLE and go to CALC. Otherwise go to IDLE.
- Adder drive:
  - In CALC: add_a = A[idx slice], add_b = B[idx slice], add_cin = carry register. These are combinational from registers.
  - In IDLE and DONE, all adder drive outputs are 0.
- Arithmetic: unsigned. result = (A + B + cin) mod 2^W. overflow = bit W of the true sum.
- start while busy=1 is ignored. The operands in flight are not disturbed.
- op_a, op_b and carry_in are sampled only at the accepting edge. Later changes have no effect on the operation in flight.
- An asynchronous rst at any point, including mid-CALC, returns all state and outputs to their reset values immediately. The partial operation is discarded and no done is produced.

## Timing
- Accepting edge = E0. CALC occupies the cycles after E0 through E_NUM_WORDS. result and overflow update at E_NUM_WORDS.
- done is high for the cycle following E_NUM_WORDS. With defaults, done is high in cycle 5 after the start edge.
- Latency from accepted start to done = NUM_WORDS+1 cycles. Back-to-back throughput is one operation per NUM_WORDS+1 cycles when start is held high.
- The external adder is treated as purely combinational. Its path must settle within one clk period.

## Configuration
- SERIAL_ADD_SUB_EN defined:
  - adds an input port `sub` (1 bit), latched with the operands.
  - when sub=1, the latched B is stored as ~op_b and the initial carry is forced to 1, ignoring carry_in. result = A − B mod 2^W. overflow = final carry-out, where 1 means no borrow.
  - sub=0 behaves identically to the undefined case.
- SERIAL_ADD_SUB_EN undefined: no `sub` port; addition only.

## Test plan
- op_a=0x1234, op_b=0x4321, carry_in=0, start pulsed: busy for 4 cycles, done pulses in cycle 5, result=0x5555, overflow=0.
- op_a=0xFFFF, op_b=0x0001, carry_in=0: the carry ripples through all 4 slices. Expect result=0x0000, overflow=1, and add_cin=1 in CALC cycles 2–4.
- op_a=0x0FFF, op_b=0x0000, carry_in=1: result=0x1000, overflow=0.
- Start 0x0001+0x0001, then pulse start with 0xFFFF+0xFFFF in CALC cycle 2. The second start is ignored: result=0x0002, exactly one done. Holding start in DONE launches the next operation with no IDLE cycle.
- Assert rst during CALC cycle 2 of 0xAAAA+0x5555. Outputs go to 0 immediately, no done is produced, and the next clean start completes correctly.
- With SERIAL_ADD_SUB_EN defined: sub=1, op_a=0x0005, op_b=0x0007 gives result=0xFFFE, overflow=0. sub=1, 0x0007−0x0005 gives 0x0002, overflow=1.
